// File: rtl/fp_mul_pkg.sv
// Shared types, flag positions and constant helpers for the iterative
// floating-point multiplier.
package fp_mul_pkg;

   // Controller states: accept, shift-add multiply, round/pack, present.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_RND  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Operand classification after flush-to-zero of subnormals.
   typedef struct packed {
      logic zero;
      logic inf;
      logic nan;
      logic snan;
   } class_t;

   // Exception flag vector layout: {invalid, overflow, underflow, inexact}.
   localparam int unsigned FLAG_W         = 4;
   localparam int unsigned FLAG_INVALID   = 3;
   localparam int unsigned FLAG_OVERFLOW  = 2;
   localparam int unsigned FLAG_UNDERFLOW = 1;
   localparam int unsigned FLAG_INEXACT   = 0;

   // Widest word the constant helpers can build; callers keep the low W bits.
   localparam int unsigned MAX_W = 128;

   // Positive infinity: all-ones exponent, zero fraction.
   function automatic logic [MAX_W-1:0] inf_word(input int exp_w, input int man_w);
      logic [MAX_W-1:0] one_v;
      logic [MAX_W-1:0] exp_ones;
      one_v    = {{(MAX_W-1){1'b0}}, 1'b1};
      exp_ones = (one_v << exp_w) - one_v;
      return exp_ones << man_w;
   endfunction

   // Canonical quiet NaN: positive, all-ones exponent, fraction MSB set.
   function automatic logic [MAX_W-1:0] qnan_word(input int exp_w, input int man_w);
      logic [MAX_W-1:0] one_v;
      one_v = {{(MAX_W-1){1'b0}}, 1'b1};
      return inf_word(exp_w, man_w) | (one_v << (man_w - 1));
   endfunction

   // Classify one operand from its field summaries; exp==0 counts as zero
   // because subnormals are flushed.
   function automatic class_t classify(input logic exp_all_ones,
                                       input logic exp_all_zero,
                                       input logic frac_nonzero,
                                       input logic frac_msb);
      class_t c;
      c.zero = exp_all_zero;
      c.inf  = exp_all_ones && !frac_nonzero;
      c.nan  = exp_all_ones && frac_nonzero;
      c.snan = exp_all_ones && frac_nonzero && !frac_msb;
      return c;
   endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Combinational back end of the multiplier: normalise the raw mantissa
// product, round to nearest even, detect overflow/underflow and pack.
module fp_round_norm
   import fp_mul_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                       sign,
   input  logic signed [EXP_W+1:0]    exp_in,
   input  logic [2*MAN_W+1:0]         prod,
   output logic [EXP_W+MAN_W:0]       result,
   output logic [FLAG_W-1:0]          flags
);

   localparam int P_W = 2 * (MAN_W + 1);
   localparam int E_W = EXP_W + 2;
   localparam logic signed [E_W-1:0] E_MAX = E_W'((1 << EXP_W) - 1);

   logic                   msb;
   logic [MAN_W-1:0]       frac;
   logic                   guard;
   logic                   sticky;
   logic                   round_up;
   logic [MAN_W:0]         frac_rnd;
   logic signed [E_W-1:0]  e_rnd;

   // Normalise, round and clamp the product into a packed result with flags.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path infers a latch.
      result = '0;
      flags  = '0;

      // Product of two 1.x mantissas lies in [1,4); MSB set means the
      // binary point moves one place and the exponent grows by one.
      msb = prod[P_W-1];
      if (msb) begin
         frac   = prod[P_W-2 -: MAN_W];
         guard  = prod[MAN_W];
         sticky = |prod[MAN_W-1:0];
      end else begin
         frac   = prod[P_W-3 -: MAN_W];
         guard  = prod[MAN_W-1];
         sticky = |prod[MAN_W-2:0];
      end

      // Round to nearest, ties to even.
      round_up = guard && (sticky || frac[0]);
      frac_rnd = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};

      // A mantissa carry-out leaves the fraction at zero and bumps the exponent.
      e_rnd = exp_in
            + $signed({{(E_W-1){1'b0}}, msb})
            + $signed({{(E_W-1){1'b0}}, frac_rnd[MAN_W]});

      result               = {sign, e_rnd[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
      flags[FLAG_INEXACT]  = guard || sticky;

      if (!e_rnd[E_W-1] && (e_rnd >= E_MAX)) begin
         result                = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags[FLAG_OVERFLOW]  = 1'b1;
         flags[FLAG_INEXACT]   = 1'b1;
      end else if (e_rnd[E_W-1] || (e_rnd == '0)) begin
         result                = {sign, {(EXP_W+MAN_W){1'b0}}};
         flags[FLAG_UNDERFLOW] = 1'b1;
         flags[FLAG_INEXACT]   = 1'b1;
      end
   end

endmodule

// File: rtl/fp_mul_iter.sv
// Iterative floating-point multiplier: one multiplier bit per cycle,
// valid/ready on both sides, special values resolved at accept time.
module fp_mul_iter
   import fp_mul_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [EXP_W+MAN_W:0]    a,
   input  logic [EXP_W+MAN_W:0]    b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [EXP_W+MAN_W:0]    result,
   output logic [FLAG_W-1:0]       flags
);

   localparam int W     = 1 + EXP_W + MAN_W;
   localparam int P_W   = 2 * (MAN_W + 1);
   localparam int E_W   = EXP_W + 2;
   localparam int CNT_W = $clog2(MAN_W + 2);

   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(MAN_W);
   localparam logic signed [E_W-1:0] BIAS     = E_W'((1 << (EXP_W - 1)) - 1);

   localparam logic [MAX_W-1:0] QNAN_FULL = qnan_word(EXP_W, MAN_W);
   localparam logic [MAX_W-1:0] INF_FULL  = inf_word(EXP_W, MAN_W);
   localparam logic [W-1:0]     QNAN      = QNAN_FULL[W-1:0];
   localparam logic [W-1:0]     INF_POS   = INF_FULL[W-1:0];

   // Operand fields
   logic               a_sign, b_sign, prod_sign;
   logic [EXP_W-1:0]   a_exp, b_exp;
   logic [MAN_W-1:0]   a_frac, b_frac;
   class_t             a_cls, b_cls;

   // Special-case decode
   logic               spec_hit;
   logic [W-1:0]       spec_result;
   logic [FLAG_W-1:0]  spec_flags;

   // State
   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [P_W-1:0]         acc_q, acc_d;
   logic [P_W-1:0]         mcand_q, mcand_d;
   logic [MAN_W:0]         mplier_q, mplier_d;
   logic                   sign_q, sign_d;
   logic signed [E_W-1:0]  exp_q, exp_d;
   logic [W-1:0]           result_q, result_d;
   logic [FLAG_W-1:0]      flags_q, flags_d;

   // Round/pack stage output
   logic [W-1:0]           rn_result;
   logic [FLAG_W-1:0]      rn_flags;

   assign a_sign    = a[W-1];
   assign b_sign    = b[W-1];
   assign a_exp     = a[W-2:MAN_W];
   assign b_exp     = b[W-2:MAN_W];
   assign a_frac    = a[MAN_W-1:0];
   assign b_frac    = b[MAN_W-1:0];
   assign prod_sign = a_sign ^ b_sign;

   // Classify operands and pick the result for NaN/inf/zero inputs.
   always_comb begin
      a_cls = classify(&a_exp, ~|a_exp, |a_frac, a_frac[MAN_W-1]);
      b_cls = classify(&b_exp, ~|b_exp, |b_frac, b_frac[MAN_W-1]);

      spec_hit    = 1'b1;
      spec_result = '0;
      spec_flags  = '0;
      if (a_cls.nan || b_cls.nan) begin
         spec_result              = QNAN;
         spec_flags[FLAG_INVALID] = a_cls.snan || b_cls.snan;
      end else if ((a_cls.inf && b_cls.zero) || (a_cls.zero && b_cls.inf)) begin
         spec_result              = QNAN;
         spec_flags[FLAG_INVALID] = 1'b1;
      end else if (a_cls.inf || b_cls.inf) begin
         spec_result = {prod_sign, INF_POS[W-2:0]};
      end else if (a_cls.zero || b_cls.zero) begin
         spec_result = {prod_sign, {(W-1){1'b0}}};
      end else begin
         spec_hit = 1'b0;
      end
   end

   // Controller next state, shift-add datapath and handshake outputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      sign_d    = sign_q;
      exp_d     = exp_q;
      result_d  = result_q;
      flags_d   = flags_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               sign_d   = prod_sign;
               exp_d    = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS;
               cnt_d    = '0;
               acc_d    = '0;
               mcand_d  = {{(MAN_W+1){1'b0}}, 1'b1, a_frac};
               mplier_d = {1'b1, b_frac};
               if (spec_hit) begin
                  result_d = spec_result;
                  flags_d  = spec_flags;
                  state_d  = ST_DONE;
               end else begin
                  state_d  = ST_MUL;
               end
            end
         end

         ST_MUL: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_RND;
            end
         end

         ST_RND: begin
            result_d = rn_result;
            flags_d  = rn_flags;
            state_d  = ST_DONE;
         end

         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   fp_round_norm #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_round_norm (
      .sign   (sign_q),
      .exp_in (exp_q),
      .prod   (acc_q),
      .result (rn_result),
      .flags  (rn_flags)
   );

   assign result = result_q;
   assign flags  = flags_q;

endmodule
